// File: rtl/rggen_native_cmd_bridge.sv
// Command-stream master for the rggen native CSR bus: buffers commands, issues them one at a time.
// Optional watchdog: define RGGEN_NATIVE_CMD_BRIDGE_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES.
module rggen_native_cmd_bridge #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int STROBE_WIDTH   = BUS_WIDTH / 8,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [STROBE_WIDTH-1:0]  i_cmd_strobe,
  output logic                     o_csrbus_valid,
  output logic [1:0]               o_csrbus_access,
  output logic [ADDRESS_WIDTH-1:0] o_csrbus_address,
  output logic [BUS_WIDTH-1:0]     o_csrbus_write_data,
  output logic [STROBE_WIDTH-1:0]  o_csrbus_strobe,
  input  logic                     i_csrbus_ready,
  input  logic [1:0]               i_csrbus_status,
  input  logic [BUS_WIDTH-1:0]     i_csrbus_read_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [1:0]               o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data
);
  localparam int PW = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     data;
    logic [STROBE_WIDTH-1:0]  strobe;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  cmd_t        mem [CMD_DEPTH];
  cmd_t        head;
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;
  state_t      state;
  logic        loaded;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign o_cmd_ready = !full;
  assign push        = i_cmd_valid && !full;
  assign head        = mem[rd_ptr[PW-1:0]];

  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == IDLE)     pop = !loaded;
      else if (state == RSP) pop = i_rsp_ready;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {i_cmd_write, i_cmd_address, i_cmd_write_data, i_cmd_strobe};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef RGGEN_NATIVE_CMD_BRIDGE_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // From IDLE the popped head sits one cycle in the request registers before valid rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      loaded              <= 1'b0;
      o_csrbus_valid      <= 1'b0;
      o_csrbus_access     <= 2'b10;
      o_csrbus_address    <= '0;
      o_csrbus_write_data <= '0;
      o_csrbus_strobe     <= '0;
      o_rsp_valid         <= 1'b0;
      o_rsp_status        <= '0;
      o_rsp_read_data     <= '0;
`ifdef RGGEN_NATIVE_CMD_BRIDGE_TIMEOUT_EN
      cnt                 <= '0;
`endif
    end else begin
      if (pop) begin
        o_csrbus_access     <= {1'b1, head.write};
        o_csrbus_address    <= head.address;
        o_csrbus_write_data <= head.data;
        o_csrbus_strobe     <= head.strobe;
      end
      case (state)
        IDLE: begin
          if (loaded) begin
            loaded         <= 1'b0;
            state          <= REQ;
            o_csrbus_valid <= 1'b1;
`ifdef RGGEN_NATIVE_CMD_BRIDGE_TIMEOUT_EN
            cnt            <= '0;
`endif
          end else if (pop) begin
            loaded <= 1'b1;
          end
        end
        REQ: begin
          if (i_csrbus_ready) begin
            o_csrbus_valid  <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rsp_status    <= i_csrbus_status;
            o_rsp_read_data <= o_csrbus_access[0] ? '0 : i_csrbus_read_data;
            state           <= RSP;
          end
`ifdef RGGEN_NATIVE_CMD_BRIDGE_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            o_csrbus_valid  <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rsp_status    <= 2'b10;
            o_rsp_read_data <= '0;
            state           <= RSP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            if (pop) begin
              state          <= REQ;
              o_csrbus_valid <= 1'b1;
`ifdef RGGEN_NATIVE_CMD_BRIDGE_TIMEOUT_EN
              cnt            <= '0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rggen_native_cmd_bridge.sv
// Bench for rggen_native_cmd_bridge: vector table, directed corner sequences, randomized scoreboard.
module tb_rggen_native_cmd_bridge;
  logic        i_clk, i_rst_n;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [7:0]  i_cmd_address;
  logic [31:0] i_cmd_write_data;
  logic [3:0]  i_cmd_strobe;
  logic        o_csrbus_valid;
  logic [1:0]  o_csrbus_access;
  logic [7:0]  o_csrbus_address;
  logic [31:0] o_csrbus_write_data;
  logic [3:0]  o_csrbus_strobe;
  logic        i_csrbus_ready;
  logic [1:0]  i_csrbus_status;
  logic [31:0] i_csrbus_read_data;
  logic        o_rsp_valid, i_rsp_ready;
  logic [1:0]  o_rsp_status;
  logic [31:0] o_rsp_read_data;

  int errors = 0;
  int checks = 0;

  rggen_native_cmd_bridge #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_address(i_cmd_address), .i_cmd_write_data(i_cmd_write_data), .i_cmd_strobe(i_cmd_strobe),
    .o_csrbus_valid(o_csrbus_valid), .o_csrbus_access(o_csrbus_access),
    .o_csrbus_address(o_csrbus_address), .o_csrbus_write_data(o_csrbus_write_data),
    .o_csrbus_strobe(o_csrbus_strobe), .i_csrbus_ready(i_csrbus_ready),
    .i_csrbus_status(i_csrbus_status), .i_csrbus_read_data(i_csrbus_read_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_status(o_rsp_status), .o_rsp_read_data(o_rsp_read_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic w; logic [7:0] a; logic [31:0] d; logic [3:0] s;
    int dly; logic [1:0] sst; logic [31:0] srd;
    logic [1:0] e_acc; logic [1:0] e_st; logic [31:0] e_rd; int e_vcyc;
  } vec_t;

  typedef struct { logic w; logic [7:0] a; logic [31:0] d; logic [3:0] s; } cmd_t;
  typedef struct { logic [1:0] st; logic [31:0] d; } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  vec_t vt[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_address = a; i_cmd_write_data = d; i_cmd_strobe = s;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_bus(input string nm);
    int n = 0;
    while (!o_csrbus_valid && n < 30) begin tick(); n++; end
    chk(nm, o_csrbus_valid, 1);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_cmd_ready"}, o_cmd_ready, 1);
    chk({p, "_bus_valid"}, o_csrbus_valid, 0);
    chk({p, "_access"}, o_csrbus_access, 2'b10);
    chk({p, "_addr"}, o_csrbus_address, 0);
    chk({p, "_wdata"}, o_csrbus_write_data, 0);
    chk({p, "_strobe"}, o_csrbus_strobe, 0);
    chk({p, "_rsp_valid"}, o_rsp_valid, 0);
    chk({p, "_rsp_status"}, o_rsp_status, 0);
    chk({p, "_rsp_data"}, o_rsp_read_data, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int vc = 0;
    string p = $sformatf("vec%0d", idx);
    chk({p, "_ready"}, o_cmd_ready, 1);
    push_cmd(v.w, v.a, v.d, v.s);
    chk({p, "_t1"}, o_csrbus_valid, 0);
    tick();
    chk({p, "_t2"}, o_csrbus_valid, 0);
    tick();
    chk({p, "_issue"}, o_csrbus_valid, 1);
    chk({p, "_access"}, o_csrbus_access, v.e_acc);
    chk({p, "_addr"}, o_csrbus_address, v.a);
    chk({p, "_wdata"}, o_csrbus_write_data, v.d);
    chk({p, "_strobe"}, o_csrbus_strobe, v.s);
    for (int i = 0; i < 20; i++) begin
      if (!o_csrbus_valid) break;
      vc++;
      if (vc == v.dly) begin
        i_csrbus_ready = 1'b1; i_csrbus_status = v.sst; i_csrbus_read_data = v.srd;
      end
      tick();
      i_csrbus_ready = 1'b0;
    end
    chk({p, "_vcycles"}, vc, v.e_vcyc);
    repeat (3) begin
      chk({p, "_rsp_valid"}, o_rsp_valid, 1);
      chk({p, "_rsp_status"}, o_rsp_status, v.e_st);
      chk({p, "_rsp_data"}, o_rsp_read_data, v.e_rd);
      chk({p, "_bus_idle"}, o_csrbus_valid, 0);
      tick();
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk({p, "_rsp_done"}, o_rsp_valid, 0);
    chk({p, "_no_reissue"}, o_csrbus_valid, 0);
  endtask

  initial begin
    vt[0] = '{1'b0, 8'h10, 32'h0, 4'hF, 3, 2'b00, 32'hDEADBEEF, 2'b10, 2'b00, 32'hDEADBEEF, 3};
    vt[1] = '{1'b1, 8'h04, 32'h12345678, 4'b0011, 1, 2'b00, 32'hAAAA5555, 2'b11, 2'b00, 32'h0, 1};
    vt[2] = '{1'b0, 8'h20, 32'h0, 4'hF, 2, 2'b11, 32'h0BADF00D, 2'b10, 2'b11, 32'h0BADF00D, 2};
    vt[3] = '{1'b1, 8'hFC, 32'hFFFFFFFF, 4'hF, 4, 2'b10, 32'h13572468, 2'b11, 2'b10, 32'h0, 4};
    vt[4] = '{1'b0, 8'hFF, 32'h55AA55AA, 4'h0, 1, 2'b01, 32'h0, 2'b10, 2'b01, 32'h0, 1};

    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_address = '0;
    i_cmd_write_data = '0; i_cmd_strobe = '0; i_csrbus_ready = 1'b0; i_csrbus_status = '0;
    i_csrbus_read_data = '0; i_rsp_ready = 1'b0;
    repeat (2) tick();
    chk_reset_vals("reset");
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vt[i], i);

    // FIFO fill: the first command leaves the FIFO one edge after it lands, so five pushes fill it.
    for (int k = 0; k < 5; k++) begin
      chk("fill_ready", o_cmd_ready, 1);
      push_cmd(1'b0, 8'h40 + 8'(k * 4), 32'h0, 4'hF);
    end
    chk("fill_full", o_cmd_ready, 0);
    i_cmd_valid = 1'b1; i_cmd_address = 8'hEE;
    repeat (2) tick();
    i_cmd_valid = 1'b0;
    chk("fill_still_full", o_cmd_ready, 0);
    for (int n = 0; n < 5; n++) begin
      wait_bus("fill_issue");
      chk("fill_addr", o_csrbus_address, 8'h40 + n * 4);
      i_csrbus_ready = 1'b1; i_csrbus_status = 2'b00; i_csrbus_read_data = 32'hC0DE0000 + n;
      tick();
      i_csrbus_ready = 1'b0;
      chk("fill_rsp_valid", o_rsp_valid, 1);
      chk("fill_rsp_data", o_rsp_read_data, 32'hC0DE0000 + n);
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      chk("fill_rsp_done", o_rsp_valid, 0);
      if (n < 4) chk("fill_b2b", o_csrbus_valid, 1);
    end
    repeat (5) tick();
    chk("fill_no_extra", o_csrbus_valid, 0);
    chk("fill_ready_again", o_cmd_ready, 1);

    // Response backpressure with a queued command.
    push_cmd(1'b0, 8'h30, 32'h0, 4'hF);
    wait_bus("bp_issue_a");
    i_csrbus_ready = 1'b1; i_csrbus_status = 2'b00; i_csrbus_read_data = 32'h11111111;
    tick();
    i_csrbus_ready = 1'b0;
    push_cmd(1'b0, 8'h34, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      chk("bp_bus_held", o_csrbus_valid, 0);
      chk("bp_rsp_held", o_rsp_valid, 1);
      tick();
    end
    i_rsp_ready = 1'b1;
    chk("bp_bus_before_hs", o_csrbus_valid, 0);
    tick();
    i_rsp_ready = 1'b0;
    chk("bp_b2b_valid", o_csrbus_valid, 1);
    chk("bp_b2b_rsp", o_rsp_valid, 0);
    chk("bp_b2b_addr", o_csrbus_address, 8'h34);
    i_csrbus_ready = 1'b1; i_csrbus_read_data = 32'h22222222;
    tick();
    i_csrbus_ready = 1'b0;
    chk("bp_rsp_b", o_rsp_read_data, 32'h22222222);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;

`ifdef RGGEN_NATIVE_CMD_BRIDGE_TIMEOUT_EN
    begin
      int vc = 0;
      push_cmd(1'b0, 8'h50, 32'h0, 4'hF);
      wait_bus("to_issue");
      i_csrbus_read_data = 32'hFFFFFFFF; i_csrbus_status = 2'b00;
      while (o_csrbus_valid && vc < 40) begin vc++; tick(); end
      chk("to_vcycles", vc, 8);
      chk("to_rsp_valid", o_rsp_valid, 1);
      chk("to_status", o_rsp_status, 2'b10);
      chk("to_data", o_rsp_read_data, 0);
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
    end
`endif

    // Asynchronous reset in the middle of a bus request.
    push_cmd(1'b1, 8'h60, 32'hCAFEF00D, 4'hF);
    push_cmd(1'b0, 8'h64, 32'h0, 4'hF);
    wait_bus("mid_issue");
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    i_rst_n = 1'b1;
    repeat (6) tick();
    chk("midrst_no_bus", o_csrbus_valid, 0);
    chk("midrst_no_rsp", o_rsp_valid, 0);

    // Randomized traffic against an in-order scoreboard.
    begin
      logic bus_seen = 1'b0;
      int   delay = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        if (cyc >= 1500 && exp_cmd.size() == 0 && exp_rsp.size() == 0) break;
        chk("rnd_exclusive", o_csrbus_valid & o_rsp_valid, 0);
        i_csrbus_ready = 1'b0;
        i_csrbus_status = 2'($urandom_range(0, 3));
        i_csrbus_read_data = $urandom;
        if (o_csrbus_valid) begin
          if (!bus_seen) begin
            chk("rnd_bus_expected", exp_cmd.size() != 0, 1);
            if (exp_cmd.size() != 0) begin
              chk("rnd_access", o_csrbus_access, {1'b1, exp_cmd[0].w});
              chk("rnd_addr", o_csrbus_address, exp_cmd[0].a);
              chk("rnd_wdata", o_csrbus_write_data, exp_cmd[0].d);
              chk("rnd_strobe", o_csrbus_strobe, exp_cmd[0].s);
            end
            bus_seen = 1'b1;
            delay = $urandom_range(0, 3);
          end
          if (delay == 0 && exp_cmd.size() != 0) begin
            rsp_t r;
            i_csrbus_ready = 1'b1;
            r.st = i_csrbus_status;
            r.d  = exp_cmd[0].w ? 32'h0 : i_csrbus_read_data;
            exp_rsp.push_back(r);
            void'(exp_cmd.pop_front());
            bus_seen = 1'b0;
          end else if (delay > 0) begin
            delay--;
          end
        end else begin
          i_csrbus_ready = ($urandom_range(0, 7) == 0);
        end
        i_rsp_ready = ($urandom_range(0, 2) != 0);
        if (o_rsp_valid && i_rsp_ready) begin
          chk("rnd_rsp_expected", exp_rsp.size() != 0, 1);
          if (exp_rsp.size() != 0) begin
            chk("rnd_rsp_status", o_rsp_status, exp_rsp[0].st);
            chk("rnd_rsp_data", o_rsp_read_data, exp_rsp[0].d);
            void'(exp_rsp.pop_front());
          end
        end
        i_cmd_valid = (cyc < 1500) && ($urandom_range(0, 1) == 1);
        i_cmd_write = 1'($urandom_range(0, 1));
        i_cmd_address = 8'($urandom_range(0, 255));
        i_cmd_write_data = $urandom;
        i_cmd_strobe = 4'($urandom_range(0, 15));
        if (i_cmd_valid && o_cmd_ready)
          exp_cmd.push_back('{i_cmd_write, i_cmd_address, i_cmd_write_data, i_cmd_strobe});
        tick();
      end
      i_cmd_valid = 1'b0; i_csrbus_ready = 1'b0; i_rsp_ready = 1'b0;
      chk("rnd_drain_cmd", exp_cmd.size(), 0);
      chk("rnd_drain_rsp", exp_rsp.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
